// File: rtl/hazard_ctl_pkg.sv
// Shared definitions for the pipeline interlock controller: FSM encodings,
// timer width and default mul/div latencies.
package hazard_ctl_pkg;

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_MUL_BUSY = 2'd1,
    HZ_DIV_BUSY = 2'd2
  } hz_state_t;

  localparam int TMR_W          = 6;
  localparam int MUL_CYCLES_DEF = 4;
  localparam int DIV_CYCLES_DEF = 33;
  localparam int CNT_W_DEF      = 16;

  function automatic logic [TMR_W-1:0] md_load_val(input logic is_div,
                                                  input int   mul_n,
                                                  input int   div_n);
    return is_div ? TMR_W'(div_n) : TMR_W'(mul_n);
  endfunction

endpackage

// File: rtl/hazard_ctl_if.sv
// Hazard-control bundle between the pipeline (master) and the interlock
// controller (slave).
interface hazard_ctl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs_rn;
  logic [4:0]       id_rt_rn;
  logic             id_use_rs;
  logic             id_use_rt;
  logic [4:0]       ex_wr_rn;
  logic             ex_is_load;
  logic             id_md_req;
  logic             id_md_div;
  logic             id_hilo_rd;
  logic             ext_wait;
  logic             stat_clr;
  logic             pause;
  logic             id_bubble;
  logic             md_go;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_rs_rn, id_rt_rn, id_use_rs, id_use_rt, ex_wr_rn, ex_is_load,
           id_md_req, id_md_div, id_hilo_rd, ext_wait, stat_clr,
    input  pause, id_bubble, md_go, md_busy, md_done, stall_cnt
  );

  modport slave (
    input  id_rs_rn, id_rt_rn, id_use_rs, id_use_rt, ex_wr_rn, ex_is_load,
           id_md_req, id_md_div, id_hilo_rd, ext_wait, stat_clr,
    output pause, id_bubble, md_go, md_busy, md_done, stall_cnt
  );
endinterface

// File: rtl/hazard_ctl_md_timer.sv
// Mul/div occupancy timer: loads a cycle count on issue, free-runs down to
// zero, and flags busy plus a one-cycle done pulse after the last busy cycle.
module hz_md_timer
  import hazard_ctl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             busy,
  output logic             done,
  output logic             expire
);

  logic [TMR_W-1:0] tmr;

  always_ff @(posedge clk) begin
    if (rst) begin
      tmr  <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else if (load) begin
      tmr  <= load_val;
      busy <= (load_val != '0);
      done <= 1'b0;
    end else if (busy) begin
      tmr  <= tmr - TMR_W'(1);
      busy <= (tmr != TMR_W'(1));
      done <= (tmr == TMR_W'(1));
    end else begin
      done <= 1'b0;
    end
  end

  // High in the final busy cycle; the FSM leaves its busy state on this edge.
  assign expire = busy && (tmr == TMR_W'(1));

endmodule

// File: rtl/hazard_ctl.sv
// Pipeline interlock controller: load-use, mul/div busy and external-wait
// stalls, mul/div issue sequencing and a saturating stall-cycle counter.
module hazard_ctl
  import hazard_ctl_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctl_if.slave  hz
);

  hz_state_t        state_q, state_d;
  logic             ldu, mdh;
  logic             pause, id_bubble, md_go;
  logic             md_busy, md_done, md_expire;
  logic [CNT_W-1:0] cnt;

  assign ldu = hz.ex_is_load && (hz.ex_wr_rn != 5'd0) &&
               ((hz.id_use_rs && (hz.ex_wr_rn == hz.id_rs_rn)) ||
                (hz.id_use_rt && (hz.ex_wr_rn == hz.id_rt_rn)));
  assign mdh = md_busy && (hz.id_hilo_rd || hz.id_md_req);

  // Priority: rst > ext_wait > mul/div hazard > load-use.
  always_comb begin
    pause     = 1'b0;
    id_bubble = 1'b0;
    md_go     = 1'b0;
    if (!rst) begin
      if (hz.ext_wait) begin
        pause = 1'b1;
      end else if (mdh || ldu) begin
        pause     = 1'b1;
        id_bubble = 1'b1;
      end else begin
        md_go = hz.id_md_req;
      end
    end
  end

  hz_md_timer u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (md_go),
    .load_val (md_load_val(hz.id_md_div, MUL_CYCLES, DIV_CYCLES)),
    .busy     (md_busy),
    .done     (md_done),
    .expire   (md_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= HZ_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      HZ_RUN:      if (md_go) state_d = hz.id_md_div ? HZ_DIV_BUSY : HZ_MUL_BUSY;
      HZ_MUL_BUSY,
      HZ_DIV_BUSY: if (md_expire) state_d = HZ_RUN;
      default:     state_d = HZ_RUN;
    endcase
  end

  // Saturating stall counter; a clear request wins over the increment.
  always_ff @(posedge clk) begin
    if (rst || hz.stat_clr) cnt <= '0;
    else if (pause && !(&cnt)) cnt <= cnt + CNT_W'(1);
  end

  assign hz.pause     = pause;
  assign hz.id_bubble = id_bubble;
  assign hz.md_go     = md_go;
  assign hz.md_busy   = md_busy;
  assign hz.md_done   = md_done;
  assign hz.stall_cnt = cnt;

endmodule

// File: tb/tb_hazard_ctl.sv
// Directed bench for hazard_ctl: table of combinational priority cases plus
// multi-cycle sequences for mul/div timing, wait, reset abort and saturation.
module tb_hazard_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_s = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  hazard_ctl_if #(.CNT_W(16)) hif ();
  hazard_ctl_if #(.CNT_W(4))  sif ();

  hazard_ctl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .hz (hif)
  );

  hazard_ctl #(.MUL_CYCLES(4), .DIV_CYCLES(33), .CNT_W(4)) dut_s (
    .clk (clk), .rst (rst_s), .hz (sif)
  );

  typedef struct {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt;
    logic [4:0] ex_wr;
    logic       ex_load, md_req, md_div, hilo, ext_wait;
    logic       pause, bubble, go;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic clear_in();
    hif.id_rs_rn = 5'd0; hif.id_rt_rn = 5'd0;
    hif.id_use_rs = 1'b0; hif.id_use_rt = 1'b0;
    hif.ex_wr_rn = 5'd0; hif.ex_is_load = 1'b0;
    hif.id_md_req = 1'b0; hif.id_md_div = 1'b0;
    hif.id_hilo_rd = 1'b0; hif.ext_wait = 1'b0; hif.stat_clr = 1'b0;
  endtask

  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_in();
    next_cyc();
    rst = 1'b0;
  endtask

  int stalls, bubbles, dones;
  bit released;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rs     rt     urs   urt   exwr   ld    req   div   hilo  wait   pause bub   go
    tbl[0]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0};
    tbl[1]  = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0};
    tbl[2]  = '{5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0};
    tbl[3]  = '{5'd3, 5'd9, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0};
    tbl[4]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0};
    tbl[5]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0};
    tbl[7]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b1};
    tbl[8]  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,  1'b1, 1'b1, 1'b0};
    tbl[9]  = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,  1'b1, 1'b0, 1'b0};
    tbl[10] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  1'b0, 1'b0, 1'b0};
    tbl[11] = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  1'b0, 1'b0, 1'b0};

    clear_in();
    sif.id_rs_rn = 5'd0; sif.id_rt_rn = 5'd0; sif.id_use_rs = 1'b0; sif.id_use_rt = 1'b0;
    sif.ex_wr_rn = 5'd0; sif.ex_is_load = 1'b0; sif.id_md_req = 1'b0; sif.id_md_div = 1'b0;
    sif.id_hilo_rd = 1'b0; sif.ext_wait = 1'b0; sif.stat_clr = 1'b0;

    // Reset: outputs forced low even with stall/issue requests present.
    rst = 1'b1;
    hif.ext_wait = 1'b1; hif.id_md_req = 1'b1;
    next_cyc(); next_cyc();
    @(negedge clk);
    chk("rst_pause", hif.pause, 0);
    chk("rst_bubble", hif.id_bubble, 0);
    chk("rst_md_go", hif.md_go, 0);
    chk("rst_md_busy", hif.md_busy, 0);
    chk("rst_md_done", hif.md_done, 0);
    chk("rst_stall_cnt", hif.stall_cnt, 0);
    next_cyc();
    do_reset();

    // Combinational priority table, each vector from a freshly reset RUN state.
    for (int i = 0; i < 12; i++) begin
      hif.id_rs_rn = tbl[i].rs; hif.id_rt_rn = tbl[i].rt;
      hif.id_use_rs = tbl[i].use_rs; hif.id_use_rt = tbl[i].use_rt;
      hif.ex_wr_rn = tbl[i].ex_wr; hif.ex_is_load = tbl[i].ex_load;
      hif.id_md_req = tbl[i].md_req; hif.id_md_div = tbl[i].md_div;
      hif.id_hilo_rd = tbl[i].hilo; hif.ext_wait = tbl[i].ext_wait;
      @(negedge clk);
      chk($sformatf("vec%0d_pause", i), hif.pause, tbl[i].pause);
      chk($sformatf("vec%0d_bubble", i), hif.id_bubble, tbl[i].bubble);
      chk($sformatf("vec%0d_md_go", i), hif.md_go, tbl[i].go);
      next_cyc();
      do_reset();
    end

    // Mul: busy 4 cycles, done on the 5th; a second mul while busy stalls.
    hif.id_md_req = 1'b1; hif.id_md_div = 1'b0;
    @(negedge clk);
    chk("mul_go", hif.md_go, 1);
    for (int k = 1; k <= 6; k++) begin
      next_cyc();
      hif.id_md_req = (k == 2);
      @(negedge clk);
      chk($sformatf("mul_busy_k%0d", k), hif.md_busy, (k <= 4) ? 1 : 0);
      chk($sformatf("mul_done_k%0d", k), hif.md_done, (k == 5) ? 1 : 0);
      if (k == 2) begin
        chk("mul_second_go", hif.md_go, 0);
        chk("mul_second_pause", hif.pause, 1);
        chk("mul_second_bubble", hif.id_bubble, 1);
      end
    end
    chk("mul_stall_cnt", hif.stall_cnt, 1);

    // Div with mfhi waiting: stall until md_done, released in that cycle.
    do_reset();
    hif.id_md_req = 1'b1; hif.id_md_div = 1'b1;
    @(negedge clk);
    chk("div_go", hif.md_go, 1);
    stalls = 0; bubbles = 0; released = 0;
    for (int k = 1; k <= 40 && !released; k++) begin
      next_cyc();
      hif.id_md_req = 1'b0;
      hif.id_hilo_rd = (k >= 3);
      @(negedge clk);
      if (k >= 3) begin
        if (hif.pause) begin
          stalls++;
          if (hif.id_bubble) bubbles++;
        end else begin
          released = 1;
          chk("div_release_cycle", k, 34);
          chk("div_release_done", hif.md_done, 1);
          chk("div_release_busy", hif.md_busy, 0);
          chk("div_stall_cycles", stalls, 31);
          chk("div_bubble_cycles", bubbles, 31);
          chk("div_stall_cnt", hif.stall_cnt, 31);
        end
      end
    end
    chk("div_release_seen", released, 1);

    // ext_wait over a load-use: pause without bubble, then one bubble cycle.
    do_reset();
    hif.ex_is_load = 1'b1; hif.ex_wr_rn = 5'd7; hif.id_rs_rn = 5'd7; hif.id_use_rs = 1'b1;
    hif.ext_wait = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wait_pause_%0d", k), hif.pause, 1);
      chk($sformatf("wait_bubble_%0d", k), hif.id_bubble, 0);
      next_cyc();
    end
    hif.ext_wait = 1'b0;
    @(negedge clk);
    chk("wait_ldu_pause", hif.pause, 1);
    chk("wait_ldu_bubble", hif.id_bubble, 1);
    next_cyc();
    hif.ex_is_load = 1'b0;
    @(negedge clk);
    chk("wait_run_pause", hif.pause, 0);
    chk("wait_run_bubble", hif.id_bubble, 0);
    chk("wait_stall_cnt", hif.stall_cnt, 4);

    // Reset at div cycle 10 aborts the unit with no done pulse.
    do_reset();
    hif.id_md_req = 1'b1; hif.id_md_div = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      next_cyc();
      hif.id_md_req = 1'b0;
      hif.id_hilo_rd = (k >= 5);
    end
    @(negedge clk);
    chk("abort_busy_before", hif.md_busy, 1);
    chk("abort_cnt_before", hif.stall_cnt, 5);
    next_cyc();
    rst = 1'b1;
    clear_in();
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_busy", hif.md_busy, 0);
    chk("abort_done", hif.md_done, 0);
    chk("abort_stall_cnt", hif.stall_cnt, 0);
    dones = 0;
    for (int k = 0; k < 30; k++) begin
      next_cyc();
      @(negedge clk);
      if (hif.md_done || hif.md_busy) dones++;
    end
    chk("abort_no_pulse", dones, 0);

    // 4-bit counter: saturates at 15, stat_clr wins over increment.
    next_cyc();
    rst_s = 1'b0;
    sif.ext_wait = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      next_cyc();
      if (k == 10) begin
        @(negedge clk);
        chk("sat_cnt_10", sif.stall_cnt, 10);
        next_cyc();
        k++;
      end
    end
    @(negedge clk);
    chk("sat_cnt_hold", sif.stall_cnt, 15);
    next_cyc();
    sif.stat_clr = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("sat_clr", sif.stall_cnt, 0);
    sif.stat_clr = 1'b0;
    next_cyc();
    @(negedge clk);
    chk("sat_resume", sif.stall_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
